// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared types and default sizes for the write-back stage and register file.
//   DEFAULT_WIDTH  : data word width (32)
//   DEFAULT_ADDR_W : register address width (4)
//   NUM_REGS       : number of architectural registers (2**DEFAULT_ADDR_W)
//   word_t, reg_addr_t, wb_req_t : data word, register index, held write
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;

    typedef logic [DEFAULT_WIDTH-1:0]  word_t;
    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        word_t     data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_stage_decoder4x16.sv
// ---------------------------------------------------------------------------
// decoder2x4 / decoder4x16
//   One-hot address decoders. decoder4x16 is composed of one 2-to-4 decoder
//   on the upper address bits that selects which of four 2-to-4 decoders on
//   the lower bits is enabled.
//   Ports (decoder4x16):
//     en     in   1          global enable; all outputs 0 when low
//     addr   in   4          address to decode
//     onehot out  NUM_REGS   one-hot select, bit[addr] set when en=1
// ---------------------------------------------------------------------------
module decoder2x4 (
    input  logic       en,
    input  logic [1:0] addr,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

module decoder4x16
    import regfile_pkg::*;
(
    input  logic                en,
    input  logic [3:0]          addr,
    output logic [NUM_REGS-1:0] onehot
);

    logic [3:0] grp_en;

    // Upper bits pick one group of four; lower bits pick within the group.
    decoder2x4 u_dec_hi (
        .en     (en),
        .addr   (addr[3:2]),
        .onehot (grp_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_dec_lo
        decoder2x4 u_dec_lo (
            .en     (grp_en[g]),
            .addr   (addr[1:0]),
            .onehot (onehot[g*4 +: 4])
        );
    end

endmodule

// File: rtl/regfile_wb_stage.sv
// ---------------------------------------------------------------------------
// regfile_wb_stage
//   Write-back pipeline register in front of a 16x32 register file with two
//   combinational read ports. A write request is held for one cycle
//   (pend_*) and committed on the following edge through a one-hot decoder.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : reads matching the held write return the held data
//     undefined : reads return array contents only; consumer stalls on
//                 pend_valid/pend_addr matches
//
//   Ports:
//     clk        in   1       rising-edge clock
//     reset_n    in   1       asynchronous active-low reset
//     wr_en      in   1       write request valid
//     wr_addr    in   ADDR_W  destination register
//     wr_data    in   WIDTH   write data
//     rd_addr_a  in   ADDR_W  read port A address
//     rd_addr_b  in   ADDR_W  read port B address
//     rd_data_a  out  WIDTH   read port A data (combinational)
//     rd_data_b  out  WIDTH   read port B data (combinational)
//     pend_valid out  1       a write is held in the write-back register
//     pend_addr  out  ADDR_W  destination of the held write (0 when idle)
// ---------------------------------------------------------------------------
module regfile_wb_stage
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr
);

    // The decoder and the package types fix the geometry at 16 x 32.
    if (WIDTH != DEFAULT_WIDTH || ADDR_W != DEFAULT_ADDR_W) begin : g_bad_geometry
        $error("regfile_wb_stage supports only WIDTH=32, ADDR_W=4");
    end

    wb_req_t             pend_d;
    wb_req_t             pend_q;
    word_t               regs_d [NUM_REGS];
    word_t               regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    // ---- S1 capture: request -> write-back register ----
    // Address and data are forced to 0 when idle so that undriven inputs
    // never reach state and pend_addr reads 0 with no write held.
    always_comb begin
        pend_d.valid = wr_en;
        pend_d.addr  = wr_en ? wr_addr : '0;
        pend_d.data  = wr_en ? wr_data : '0;
    end

    // ---- S2 commit: write-back register -> array ----
    decoder4x16 u_wr_dec (
        .en     (pend_q.valid),
        .addr   (pend_q.addr),
        .onehot (wr_sel)
    );

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = wr_sel[i] ? pend_q.data : regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ---- Read ports ----
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // Forward the held write so a dependent read sees it one cycle early.
        if (pend_q.valid && (pend_q.addr == rd_addr_a)) begin
            rd_data_a = pend_q.data;
        end
        if (pend_q.valid && (pend_q.addr == rd_addr_b)) begin
            rd_data_b = pend_q.data;
        end
`endif
    end

    assign pend_valid = pend_q.valid;
    assign pend_addr  = pend_q.addr;

endmodule

// File: tb/tb_regfile_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_stage
//   Self-checking bench for regfile_wb_stage. A reference model holds the
//   architectural register contents plus the single write waiting to land,
//   and predicts every read and the pending-write status.
// ---------------------------------------------------------------------------
module tb_regfile_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        pend_valid;
    logic [3:0]  pend_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: committed contents and the write still in flight.
    logic [31:0] mem [16];
    logic        m_pv;
    logic [3:0]  m_pa;
    logic [31:0] m_pd;

    regfile_wb_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr)
    );

    always #50 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
        if (m_pv && a == m_pa) return m_pd;
`endif
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        m_pv = 1'b0;
        m_pa = '0;
        m_pd = '0;
    endtask

    // Advance one clock: the previously accepted write lands, the new one
    // (if any) becomes pending. Returns 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            if (m_pv) mem[m_pa] = m_pd;
            m_pv = wr_en;
            m_pa = wr_en ? wr_addr : 4'd0;
            m_pd = wr_en ? wr_data : 32'd0;
        end
        #2;
    endtask

    task automatic test_reset();
        // Power-on reset pulse.
        #5 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        // Fill the array with random writes, then reset in mid-cycle.
        for (int c = 0; c < 24; c++) begin
            wr_en   = 1'b1;
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom | 32'h1;
            tick();
        end
        wr_en = 1'b0;
        #20 reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            #1;
            n_cmp++;
            if (rd_data_a !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_rd_a addr=%0d got=%h want=00000000", i, rd_data_a);
            end
            n_cmp++;
            if (rd_data_b !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_rd_b addr=%0d got=%h want=00000000", 15 - i, rd_data_b);
            end
        end
        n_cmp++;
        if (pend_valid !== 1'b0 || pend_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pend got=%b/%0d want=0/0", pend_valid, pend_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic_write();
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd5;
        #1;
        n_cmp++;
        if (pend_valid !== 1'b1 || pend_addr !== 4'd5) begin
            n_fail++;
            $display("FAIL basic_pend got=%b/%0d want=1/5", pend_valid, pend_addr);
        end
        n_cmp++;
        if (rd_data_a !== exp_rd(4'd5)) begin
            n_fail++;
            $display("FAIL basic_commit_cycle_rd got=%h want=%h", rd_data_a, exp_rd(4'd5));
        end
        tick();
        #1;
        n_cmp++;
        if (rd_data_a !== 32'hDEADBEEF || rd_data_b !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_visible got=%h/%h want=deadbeef", rd_data_a, rd_data_b);
        end
        n_cmp++;
        if (pend_valid !== 1'b0 || pend_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_pend_clear got=%b/%0d want=0/0", pend_valid, pend_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] snap [16];
        for (int i = 0; i < 16; i++) snap[i] = mem[i];
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd1;
        tick();
        wr_data = 32'd2;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 4'd3;
        #1;
        n_cmp++;
        if (pend_valid !== 1'b1 || pend_addr !== 4'd3) begin
            n_fail++;
            $display("FAIL b2b_pend got=%b/%0d want=1/3", pend_valid, pend_addr);
        end
        n_cmp++;
        if (rd_data_a !== exp_rd(4'd3)) begin
            n_fail++;
            $display("FAIL b2b_first got=%h want=%h", rd_data_a, exp_rd(4'd3));
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(i);
            #1;
            n_cmp++;
            if (i == 3) begin
                if (rd_data_a !== 32'd2 || rd_data_b !== 32'd2) begin
                    n_fail++;
                    $display("FAIL b2b_final got=%h/%h want=00000002", rd_data_a, rd_data_b);
                end
            end else if (rd_data_a !== snap[i] || rd_data_b !== snap[i]) begin
                n_fail++;
                $display("FAIL b2b_other addr=%0d got=%h/%h want=%h", i, rd_data_a, rd_data_b, snap[i]);
            end
        end
    endtask

    task automatic test_decode_sweep();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 32'(i) * 32'h11111111;
            tick();
            n_cmp++;
            if (pend_valid !== 1'b1 || pend_addr !== 4'(i)) begin
                n_fail++;
                $display("FAIL sweep_pend i=%0d got=%b/%0d want=1/%0d", i, pend_valid, pend_addr, i);
            end
        end
        wr_en = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(i);
            #1;
            n_cmp++;
            if (rd_data_a !== 32'(i) * 32'h11111111 || rd_data_b !== rd_data_a) begin
                n_fail++;
                $display("FAIL sweep_rd addr=%0d got=%h/%h want=%h", i, rd_data_a, rd_data_b,
                         32'(i) * 32'h11111111);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hCAFEF00D;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (pend_valid !== 1'b1 || pend_addr !== 4'd9) begin
            n_fail++;
            $display("FAIL midrst_held got=%b/%0d want=1/9", pend_valid, pend_addr);
        end
        #20 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        rd_addr_a = 4'd9;
        rd_addr_b = 4'd0;
        #1;
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_rd got=%h/%h want=00000000", rd_data_a, rd_data_b);
        end
        n_cmp++;
        if (pend_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pend got=%b want=0", pend_valid);
        end
    endtask

    task automatic test_idle_x();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i * 5); wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        tick();
        wr_addr = 'x;
        wr_data = 'x;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (pend_valid !== 1'b0 || pend_addr !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_pend cyc=%0d got=%b/%0d want=0/0", c, pend_valid, pend_addr);
            end
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            #1;
            n_cmp++;
            if (rd_data_a !== mem[i] || rd_data_b !== mem[15 - i]) begin
                n_fail++;
                $display("FAIL idle_rd addr=%0d got=%h/%h want=%h/%h", i, rd_data_a, rd_data_b,
                         mem[i], mem[15 - i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            tick();
            rd_addr_a = ($urandom_range(0, 1) != 0) ? m_pa : 4'($urandom_range(0, 15));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 4'($urandom_range(0, 15));
            #1;
            n_cmp++;
            if (rd_data_a !== exp_rd(rd_addr_a) || rd_data_b !== exp_rd(rd_addr_b)) begin
                n_fail++;
                $display("FAIL rand_rd cyc=%0d a=%0d b=%0d got=%h/%h want=%h/%h", c, rd_addr_a,
                         rd_addr_b, rd_data_a, rd_data_b, exp_rd(rd_addr_a), exp_rd(rd_addr_b));
            end
            n_cmp++;
            if (pend_valid !== m_pv || pend_addr !== m_pa) begin
                n_fail++;
                $display("FAIL rand_pend cyc=%0d got=%b/%0d want=%b/%0d", c, pend_valid,
                         pend_addr, m_pv, m_pa);
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_write();
        test_back_to_back();
        test_decode_sweep();
        test_reset_mid_write();
        test_idle_x();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
